// File: rtl/max_downscale_block.sv
// Softmax front stage: buffers one vector of FP32 logits, tracks its maximum, then streams x_i - max.
// Optional macro DOWNSCALE_MAX_OUT_EN adds downscale_max_o / downscale_max_valid_o.
module max_downscale_block #(
    parameter int NUM_ELEM   = 10,
    parameter int ADDR_WIDTH = 4
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [31:0] downscale_data_i,
    input  logic        downscale_data_valid_i,
    output logic        downscale_ready_o,
    output logic [31:0] downscale_data_o,
    output logic        downscale_data_valid_o,
`ifdef DOWNSCALE_MAX_OUT_EN
    output logic [31:0] downscale_max_o,
    output logic        downscale_max_valid_o,
`endif
    output logic        downscale_done_o
);

    typedef enum logic {COLLECT, DRAIN} state_t;

    localparam logic [31:0]           NEG_INF  = 32'hFF800000;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_ELEM - 1);

    state_t                r_state;
    state_t                w_nextState;
    logic [31:0]           r_buf [NUM_ELEM];
    logic [ADDR_WIDTH-1:0] r_wrCnt;
    logic [ADDR_WIDTH-1:0] r_rdCnt;
    logic [31:0]           r_max;
    logic [31:0]           r_dataOut;
    logic                  r_validOut;
    logic                  r_doneOut;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_lastWrite;
    logic                  w_lastRead;
    logic                  w_inGreater;
    logic [31:0]           w_maxNext;

    logic [31:0]           w_xIn;
    logic [31:0]           w_xf;
    logic [31:0]           w_yf;
    logic [31:0]           w_big;
    logic [31:0]           w_small;
    logic [26:0]           w_mantBig;
    logic [26:0]           w_mantSmall;
    logic [26:0]           w_stickyMask;
    logic [26:0]           w_aligned;
    logic [7:0]            w_expDiff;
    logic [27:0]           w_sum;
    logic [26:0]           w_norm;
    logic [9:0]            w_exp;
    logic [4:0]            w_msb;
    logic [4:0]            w_lshift;
    logic                  w_roundUp;
    logic [23:0]           w_fracRnd;
    logic [31:0]           w_diff;

    assign w_accept    = (r_state == COLLECT) && downscale_data_valid_i;
    assign w_lastWrite = w_accept && (r_wrCnt == LAST_IDX);
    assign w_lastRead  = (r_state == DRAIN) && (r_rdCnt == LAST_IDX);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        case (r_state)
            COLLECT: begin
                w_ready = 1'b1;
                if (w_lastWrite) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (w_lastRead) begin
                    w_nextState = COLLECT;
                end
            end
            default: w_nextState = COLLECT;
        endcase
    end

    // Sign-magnitude compare; +0 and -0 are equal and ties keep the stored max.
    always_comb begin
        w_inGreater = 1'b0;
        if ((downscale_data_i[30:0] == 31'd0) && (r_max[30:0] == 31'd0)) begin
            w_inGreater = 1'b0;
        end else if (downscale_data_i[31] != r_max[31]) begin
            w_inGreater = ~downscale_data_i[31];
        end else if (!downscale_data_i[31]) begin
            w_inGreater = downscale_data_i[30:0] > r_max[30:0];
        end else begin
            w_inGreater = downscale_data_i[30:0] < r_max[30:0];
        end
    end

    assign w_maxNext = w_inGreater ? downscale_data_i : r_max;

    always_ff @(posedge clock_i) begin
        if (w_accept) begin
            r_buf[r_wrCnt] <= downscale_data_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wrCnt <= '0;
            r_rdCnt <= '0;
            r_max   <= NEG_INF;
        end else begin
            if (w_accept) begin
                r_max   <= w_maxNext;
                r_wrCnt <= (r_wrCnt == LAST_IDX) ? '0 : r_wrCnt + 1'b1;
            end
            if (r_state == DRAIN) begin
                if (w_lastRead) begin
                    r_rdCnt <= '0;
                    r_max   <= NEG_INF;
                end else begin
                    r_rdCnt <= r_rdCnt + 1'b1;
                end
            end
        end
    end

    // x - max is computed as x + (-max); denormal operands are flushed to zero first.
    assign w_xIn = r_buf[r_rdCnt];
    assign w_xf  = (w_xIn[30:23] == 8'd0) ? {w_xIn[31], 31'd0} : w_xIn;
    assign w_yf  = (r_max[30:23] == 8'd0) ? {~r_max[31], 31'd0} : {~r_max[31], r_max[30:0]};

    always_comb begin
        w_big   = w_xf;
        w_small = w_yf;
        if (w_yf[30:0] > w_xf[30:0]) begin
            w_big   = w_yf;
            w_small = w_xf;
        end
    end

    always_comb begin
        w_mantBig    = {1'b1, w_big[22:0], 3'b000};
        w_mantSmall  = {1'b1, w_small[22:0], 3'b000};
        w_expDiff    = w_big[30:23] - w_small[30:23];
        w_stickyMask = '0;
        w_aligned    = 27'd1;
        if (w_expDiff < 8'd27) begin
            w_stickyMask = (27'd1 << w_expDiff) - 27'd1;
            w_aligned    = (w_mantSmall >> w_expDiff) | {26'd0, |(w_mantSmall & w_stickyMask)};
        end
        w_exp    = {2'b00, w_big[30:23]};
        w_msb    = '0;
        w_lshift = '0;
        if (w_big[31] == w_small[31]) begin
            w_sum = {1'b0, w_mantBig} + {1'b0, w_aligned};
            if (w_sum[27]) begin
                w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
                w_exp  = w_exp + 10'd1;
            end else begin
                w_norm = w_sum[26:0];
            end
        end else begin
            w_sum = {1'b0, w_mantBig} - {1'b0, w_aligned};
            for (int i = 0; i < 27; i++) begin
                if (w_sum[i]) begin
                    w_msb = i[4:0];
                end
            end
            w_lshift = 5'd26 - w_msb;
            w_norm   = w_sum[26:0] << w_lshift;
            w_exp    = w_exp - {5'd0, w_lshift};
        end
        // Round to nearest even on guard/round/sticky; a fraction carry bumps the exponent.
        w_roundUp = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
        w_fracRnd = {1'b0, w_norm[25:3]} + {23'd0, w_roundUp};
        if (w_fracRnd[23]) begin
            w_exp = w_exp + 10'd1;
        end
        w_diff = {w_big[31], w_exp[7:0], w_fracRnd[22:0]};
        if (w_big[30:23] == 8'd0) begin
            w_diff = 32'h0000_0000;
        end else if (w_small[30:23] == 8'd0) begin
            w_diff = w_big;
        end else if (!w_norm[26] || w_exp[9] || (w_exp == 10'd0)) begin
            w_diff = 32'h0000_0000;
        end else if (w_exp >= 10'd255) begin
            w_diff = {w_big[31], 8'hFF, 23'd0};
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_dataOut  <= '0;
            r_validOut <= 1'b0;
            r_doneOut  <= 1'b0;
        end else begin
            r_validOut <= (r_state == DRAIN);
            r_doneOut  <= w_lastRead;
            if (r_state == DRAIN) begin
                r_dataOut <= w_diff;
            end
        end
    end

    assign downscale_ready_o      = w_ready;
    assign downscale_data_o       = r_dataOut;
    assign downscale_data_valid_o = r_validOut;
    assign downscale_done_o       = r_doneOut;

`ifdef DOWNSCALE_MAX_OUT_EN
    logic [31:0] r_maxOut;
    logic        r_maxValid;

    // The final max (including the last sample) is captured as the vector completes.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_maxOut   <= '0;
            r_maxValid <= 1'b0;
        end else begin
            r_maxValid <= w_lastWrite;
            if (w_lastWrite) begin
                r_maxOut <= w_maxNext;
            end
        end
    end

    assign downscale_max_o       = r_maxOut;
    assign downscale_max_valid_o = r_maxValid;
`endif

endmodule

// File: doc/max_downscale_block.md
Name: max_downscale_block

Overview:
- Front stage of the softmax datapath. Collects one vector of NUM_ELEM FP32 logits and tracks its running maximum.
- After the last element it streams out x_i - max in arrival order.
- The output stream feeds the exp path and the downscale input of the second subtractor (x_i - max - ln(sum)).
- Single clock domain, fully sequential, with its own FP32 subtractor.

Parameters:
- NUM_ELEM, 10, elements per softmax vector (2..16).
- ADDR_WIDTH, 4, buffer index width; must satisfy 2^ADDR_WIDTH >= NUM_ELEM.

Ports:
- clock_i  input  1  system clock, rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- downscale_data_i  input  32  FP32 input element.
- downscale_data_valid_i  input  1  one-cycle qualifier for downscale_data_i.
- downscale_ready_o  output  1  high when an input is accepted this cycle.
- downscale_data_o  output  32  FP32 result x_i - max.
- downscale_data_valid_o  output  1  one-cycle pulse per result.
- downscale_done_o  output  1  one-cycle pulse with the last result of a vector.

Behaviour:
- Reset values: all outputs 0 except downscale_ready_o = 1 (state COLLECT); wr/rd counters 0; max register 0xFF800000 (-inf).
- Reset is asynchronous and may assert in any state. It discards the buffer, aborts any output stream, and sends the block to COLLECT. No further valid pulses are produced until new input is taken.
- FSM: COLLECT -> DRAIN -> COLLECT.
- COLLECT:
  - downscale_ready_o = 1.
  - On valid: write to buffer[wr_cnt], update max, increment wr_cnt.
  - Input pulses may be back-to-back or gapped by any number of cycles.
  - On the NUM_ELEM-th accepted sample: wr_cnt -> 0, go to DRAIN next cycle.
- DRAIN:
  - downscale_ready_o = 0. Valid pulses in DRAIN are ignored and never buffered.
  - Reads buffer[rd_cnt] each cycle for NUM_ELEM consecutive cycles.
  - After the last read: max -> -inf, rd_cnt -> 0, go to COLLECT.
- Max compare, sign-magnitude:
  - -0 and +0 compare equal; on ties the stored max is kept.
  - The compare uses the incoming sample, so the NUM_ELEM-th sample is included in max before DRAIN.
- Latency: result for read k is registered and valid exactly 1 cycle after the read cycle.
  - NUM_ELEM valid pulses back-to-back; the first arrives 2 cycles after the cycle the last input was accepted.
  - downscale_done_o coincides with the NUM_ELEM-th valid pulse.
- Next vector: ready rises the cycle after the last DRAIN read. A vector may begin while the final result is still on the output register.
- Subtraction x - max:
  - Full FP32 with exponent alignment, guard/round/sticky bits, round-to-nearest-even.
  - Denormal inputs are flushed to zero; denormal results are flushed to -0 then forced to +0.
  - Since x <= max, the result is always <= 0.
  - Exact zero result (x == max, or both zero) outputs 0x00000000.
  - NaN/inf inputs are unsupported; output is undefined but valid timing is preserved.
- downscale_data_o holds its last value between pulses.

Optional Feature:
- Macro DOWNSCALE_MAX_OUT_EN.
- When defined:
  - Extra ports downscale_max_o (output, 32) and downscale_max_valid_o (output, 1).
  - The max register is presented on downscale_max_o with a one-cycle valid pulse in the first DRAIN cycle.
  - downscale_max_o holds until the next pulse; reset value 0.
- When undefined: ports absent, no extra logic; all other behaviour identical.

Test Plan:
- Ordered vector, default NUM_ELEM=10: inputs 0x3F800000 (1.0), 0x40000000 (2.0), 0x40800000 (4.0), then seven 0x3F800000, one per 2 cycles -> ten outputs back-to-back starting 2 cycles after the 10th input.
  - Outputs: 0xC0400000, 0xC0000000, 0x00000000, then seven 0xC0400000.
  - done_o on the 10th output.
- Negative mix: max 0x3F000000 (0.5) as the 10th sample, others 0xBFC00000 (-1.5) -> nine outputs 0xC0000000 (-2.0), last output 0x00000000. Confirms a max arriving last is included.
- Equal/zero elements: ten samples alternating 0x00000000 and 0x80000000 -> all ten outputs 0x00000000; with DOWNSCALE_MAX_OUT_EN, max_o = 0x00000000.
- Back-pressure: hold valid_i=1 continuously with incrementing data -> exactly 10 accepted, ready_o low for 10 cycles, inputs during DRAIN absent from results. The next vector starts from the first sample after ready_o rises.
- Reset mid-DRAIN: assert reset_n_i=0 after 4 outputs -> valid_o, done_o and data_o go to 0 immediately and ready_o goes to 1. The next full vector produces correct results with max recomputed from -inf.
- Back-to-back vectors: second vector's first sample presented the cycle ready_o rises -> second vector's results use only the second vector's max.
